// File: rtl/cpu_seq_hilo_unit_pkg.sv
// cpu_seq_hilo_unit_pkg: shared state, select, opcode and funct encodings for the sequencer/HI-LO block.
package cpu_seq_hilo_unit_pkg;
    typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4} state_t;
    localparam logic [1:0] SRC_REG_B  = 2'd0;
    localparam logic [1:0] SRC_FOUR   = 2'd1;
    localparam logic [1:0] SRC_IMM    = 2'd2;
    localparam logic [1:0] SRC_BRANCH = 2'd3;
    localparam logic [1:0] SEL_ALU = 2'd0;
    localparam logic [1:0] SEL_HI  = 2'd1;
    localparam logic [1:0] SEL_LO  = 2'd2;
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    function automatic logic is_mult_div(input logic [5:0] fn);
        return fn == FN_MULT || fn == FN_MULTU || fn == FN_DIV || fn == FN_DIVU;
    endfunction
endpackage

// File: rtl/cpu_seq_hilo_unit_if.sv
// cpu_seq_hilo_unit_if: operand/result bus between control, register latches, ALU and the HI/LO unit.
interface cpu_seq_hilo_unit_if;
    logic [1:0]  alu_src_b;
    logic [31:0] register_b;
    logic [15:0] immediate;
    logic [5:0]  opcode;
    logic [5:0]  func_code;
    logic [31:0] reg_a;
    logic [63:0] mult_div_result;
    logic [31:0] alu_b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  hi_lo_sel;
    modport master (
        output alu_src_b, register_b, immediate, opcode, func_code, reg_a, mult_div_result,
        input  alu_b, hi, lo, hi_lo_sel
    );
    modport slave (
        input  alu_src_b, register_b, immediate, opcode, func_code, reg_a, mult_div_result,
        output alu_b, hi, lo, hi_lo_sel
    );
endinterface

// File: rtl/cpu_seq_hilo_unit_hi_lo_regs.sv
// cpu_seq_hilo_unit_hi_lo_regs: HI/LO flops, write decode and readback select.
// HILO_MOVE_TO_EN: when defined, MTHI/MTLO write hi/lo; otherwise only mult/div do.
module cpu_seq_hilo_unit_hi_lo_regs
    import cpu_seq_hilo_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [5:0]  opcode,
    input  logic [5:0]  func_code,
    input  logic [31:0] reg_a,
    input  logic [63:0] mult_div_result,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [1:0]  hi_lo_sel
);
`ifdef HILO_MOVE_TO_EN
    localparam bit MOVE_EN = 1'b1;
`else
    localparam bit MOVE_EN = 1'b0;
`endif
    logic special;
    assign special = opcode == OP_SPECIAL;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi <= '0;
            lo <= '0;
        end else if (wr_en && special) begin
            if (is_mult_div(func_code)) begin
                hi <= mult_div_result[63:32];
                lo <= mult_div_result[31:0];
            end else if (MOVE_EN && func_code == FN_MTHI) begin
                hi <= reg_a;
            end else if (MOVE_EN && func_code == FN_MTLO) begin
                lo <= reg_a;
            end
        end
    end
    assign hi_lo_sel = !special ? SEL_ALU :
                       func_code == FN_MFHI ? SEL_HI :
                       func_code == FN_MFLO ? SEL_LO : SEL_ALU;
endmodule

// File: rtl/cpu_seq_hilo_unit.sv
// cpu_seq_hilo_unit: 5-state instruction sequencer, ALU B-operand mux and HI/LO register pair.
// HILO_MOVE_TO_EN: when defined, MTHI/MTLO write hi/lo.
module cpu_seq_hilo_unit
    import cpu_seq_hilo_unit_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       stall,
    output logic [2:0] state,
    cpu_seq_hilo_unit_if.slave bus
);
    state_t      state_q, state_d;
    logic        logical_op;
    logic [31:0] imm_sext;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= FETCH;
        else state_q <= state_d;
    end
    // Illegal codes recover to FETCH even under stall so a glitch cannot wedge the CPU.
    always_comb begin
        state_d = state_q;
        if (state_q > WB) state_d = FETCH;
        else if (!stall) state_d = state_q == WB ? FETCH : state_t'(state_q + 3'd1);
    end
    assign state = state_q;
    assign logical_op = bus.opcode == OP_ANDI || bus.opcode == OP_ORI || bus.opcode == OP_XORI;
    assign imm_sext = {{16{bus.immediate[15]}}, bus.immediate};
    assign bus.alu_b = bus.alu_src_b == SRC_REG_B ? bus.register_b :
                       bus.alu_src_b == SRC_FOUR  ? 32'd4 :
                       bus.alu_src_b == SRC_IMM   ? (logical_op ? {16'd0, bus.immediate} : imm_sext) :
                       {imm_sext[29:0], 2'b00};
    cpu_seq_hilo_unit_hi_lo_regs u_hi_lo (
        .clk             (clk),
        .reset           (reset),
        .wr_en           (state_q == EXEC && !stall),
        .opcode          (bus.opcode),
        .func_code       (bus.func_code),
        .reg_a           (bus.reg_a),
        .mult_div_result (bus.mult_div_result),
        .hi              (bus.hi),
        .lo              (bus.lo),
        .hi_lo_sel       (bus.hi_lo_sel)
    );
endmodule

// File: tb/tb_cpu_seq_hilo_unit.sv
// tb_cpu_seq_hilo_unit: directed checks of sequencer, B mux and HI/LO behaviour.
module tb_cpu_seq_hilo_unit;
    logic       clk;
    logic       reset;
    logic       stall;
    logic [2:0] state;
    int         checks;
    int         failures;
    logic [31:0] hi_exp;
    cpu_seq_hilo_unit_if bus ();
    cpu_seq_hilo_unit dut (.clk(clk), .reset(reset), .stall(stall), .state(state), .bus(bus));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b0;
        stall = 1'b0;
        bus.alu_src_b = 2'd0;
        bus.register_b = 32'hCAFEBABE;
        bus.immediate = 16'hFFF0;
        bus.opcode = 6'h09;
        bus.func_code = 6'h00;
        bus.reg_a = 32'h0;
        bus.mult_div_result = 64'h0;
        #1;
        check("rst_state", 64'(state), 64'd0);
        check("rst_hi", 64'(bus.hi), 64'd0);
        check("rst_lo", 64'(bus.lo), 64'd0);
        step(1);
        check("rst_hold", 64'(state), 64'd0);
        reset = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step(1);
            check($sformatf("seq%0d", i), 64'(state), 64'(i % 5));
        end
        // MULT
        bus.opcode = 6'h00;
        bus.func_code = 6'h18;
        bus.mult_div_result = 64'h00000001_80000000;
        step(2);
        check("mult_exec_state", 64'(state), 64'd2);
        check("mult_pre_hi", 64'(bus.hi), 64'd0);
        step(1);
        check("mult_mem_state", 64'(state), 64'd3);
        check("mult_hi", 64'(bus.hi), 64'h00000001);
        check("mult_lo", 64'(bus.lo), 64'h80000000);
        step(2);
        check("mult_back_fetch", 64'(state), 64'd0);
        bus.func_code = 6'h10;
        #1 check("mfhi_sel", 64'(bus.hi_lo_sel), 64'd1);
        bus.func_code = 6'h12;
        #1 check("mflo_sel", 64'(bus.hi_lo_sel), 64'd2);
        bus.opcode = 6'h23;
        bus.func_code = 6'h10;
        #1 check("nonspecial_sel", 64'(bus.hi_lo_sel), 64'd0);
        // stall in FETCH
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check($sformatf("stall_fetch%0d", i), 64'(state), 64'd0);
        end
        stall = 1'b0;
        step(1);
        check("stall_release", 64'(state), 64'd1);
        // stall in EXEC defers the write
        step(1);
        check("exec2_state", 64'(state), 64'd2);
        stall = 1'b1;
        bus.opcode = 6'h00;
        bus.func_code = 6'h1B;
        bus.mult_div_result = 64'h12345678_9ABCDEF0;
        step(2);
        check("stall_exec_state", 64'(state), 64'd2);
        check("stall_exec_hi", 64'(bus.hi), 64'h00000001);
        stall = 1'b0;
        step(1);
        check("divu_state", 64'(state), 64'd3);
        check("divu_hi", 64'(bus.hi), 64'h12345678);
        check("divu_lo", 64'(bus.lo), 64'h9ABCDEF0);
        step(2);
        // MTHI
        bus.func_code = 6'h11;
        bus.reg_a = 32'hDEADBEEF;
`ifdef HILO_MOVE_TO_EN
        hi_exp = 32'hDEADBEEF;
`else
        hi_exp = 32'h12345678;
`endif
        step(3);
        check("mthi_hi", 64'(bus.hi), 64'(hi_exp));
        check("mthi_lo", 64'(bus.lo), 64'h9ABCDEF0);
        step(2);
        // ADDU leaves HI/LO alone
        bus.func_code = 6'h21;
        bus.mult_div_result = 64'hAAAAAAAA_55555555;
        step(3);
        check("addu_hi", 64'(bus.hi), 64'(hi_exp));
        check("addu_lo", 64'(bus.lo), 64'h9ABCDEF0);
        check("addu_sel", 64'(bus.hi_lo_sel), 64'd0);
        step(2);
        // async reset in EXEC
        step(2);
        check("pre_rst_exec", 64'(state), 64'd2);
        reset = 1'b0;
        #1;
        check("async_rst_state", 64'(state), 64'd0);
        check("async_rst_hi", 64'(bus.hi), 64'd0);
        check("async_rst_lo", 64'(bus.lo), 64'd0);
        step(1);
        reset = 1'b1;
        // B mux
        bus.immediate = 16'hFFF0;
        bus.alu_src_b = 2'd2;
        bus.opcode = 6'h09;
        #1 check("bmux_sext", 64'(bus.alu_b), 64'hFFFFFFF0);
        bus.opcode = 6'h0D;
        #1 check("bmux_ori", 64'(bus.alu_b), 64'h0000FFF0);
        bus.opcode = 6'h0C;
        #1 check("bmux_andi", 64'(bus.alu_b), 64'h0000FFF0);
        bus.opcode = 6'h0E;
        #1 check("bmux_xori", 64'(bus.alu_b), 64'h0000FFF0);
        bus.alu_src_b = 2'd3;
        #1 check("bmux_branch", 64'(bus.alu_b), 64'hFFFFFFC0);
        bus.immediate = 16'h1234;
        #1 check("bmux_branch_pos", 64'(bus.alu_b), 64'h000048D0);
        bus.alu_src_b = 2'd1;
        #1 check("bmux_four", 64'(bus.alu_b), 64'd4);
        bus.alu_src_b = 2'd0;
        #1 check("bmux_regb", 64'(bus.alu_b), 64'hCAFEBABE);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cpu_seq_hilo_unit.md
# cpu_seq_hilo_unit

Multi-cycle MIPS support block holding three small, tightly coupled functions:
- the 3-bit instruction-cycle sequencer, stalled by the memory bus;
- the ALU B-operand 4:1 selector, including immediate extension;
- the HI/LO register pair with its write and readback-select logic.

It sits between the main control decoder, register file/regA/regB latches and the ALU inside the bus-attached CPU top level.

## Interface
Parameters: none.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- stall  in  1  bus waitrequest while read/write is pending; freezes sequencer and HI/LO writes
- state  out  3  current cycle state
- alu_src_b  in  2  B-operand select
- register_b  in  32  register-file rt read data
- immediate  in  16  instruction bits [15:0]
- opcode  in  6  instruction bits [31:26]
- func_code  in  6  instruction bits [5:0]
- reg_a  in  32  latched rs operand
- mult_div_result  in  64  ALU product, or {remainder, quotient}
- alu_b  out  32  ALU B operand
- hi  out  32  HI register
- lo  out  32  LO register
- hi_lo_sel  out  2  writeback source: 0 ALUOut, 1 HI, 2 LO

## Operation
Sequencer:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
- Advances FETCH→DECODE→EXEC→MEM→WB→FETCH, one step per clock while stall=0.
- Holds its state while stall=1.
- Codes 5–7 are illegal; from an illegal code the next state is FETCH.

B mux (purely combinational):
- alu_src_b=0: register_b.
- alu_src_b=1: 32'd4.
- alu_src_b=2: immediate, zero-extended when opcode is ANDI 0x0C, ORI 0x0D or XORI 0x0E; sign-extended otherwise.
- alu_src_b=3: sign-extended immediate shifted left by 2 (branch offset).

HI/LO writes occur only when opcode=0x00, state=EXEC and stall=0:
- MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B: hi←mult_div_result[63:32], lo←mult_div_result[31:0]. For divides the ALU supplies the remainder in [63:32].
- MTHI 0x11: hi←reg_a.
- MTLO 0x13: lo←reg_a.
- All other instructions leave HI and LO unchanged.

hi_lo_sel (combinational, independent of state):
- 1 when opcode=0 and funct=MFHI 0x10.
- 2 when opcode=0 and funct=MFLO 0x12.
- 0 otherwise.
- Value 3 is never driven.

## Timing
- Reset asserted (including mid-instruction): state=FETCH, hi=0, lo=0 immediately, with no clock required.
- After reset releases, the first rising edge moves FETCH→DECODE, provided stall=0.
- Fixed instruction latency is 5 cycles plus any stall cycles.
- HI/LO update on the EXEC→MEM edge. The new values are visible from MEM onward, so an MFHI in the next instruction reads the updated value.
- alu_b and hi_lo_sel have zero latency. They follow their inputs within the same cycle.
- stall and an EXEC write in the same cycle: the write is deferred until the cycle in which stall=0, while the state is still EXEC.

## Configuration
- Macro HILO_MOVE_TO_EN.
- Defined: MTHI/MTLO write hi/lo as specified above.
- Undefined: MTHI/MTLO are ignored, HI/LO are unchanged, and only multiply/divide write them. Sequencer, B mux and hi_lo_sel are unaffected.

## Structure
- A shared package holds:
  - the state enum (FETCH..WB);
  - alu_src_b encodings;
  - hi_lo_sel encodings;
  - opcode constants (SPECIAL, ANDI, ORI, XORI);
  - funct constants (MFHI, MTHI, MFLO, MTLO, MULT, MULTU, DIV, DIVU).
- One natural sub-module is hi_lo_regs, containing the HI/LO flops, write decode and readback select. The sequencer and B mux stay in the top level.

## Test plan
- Reset then 5 clocks with stall=0: state 0,1,2,3,4,0. Asserting reset in EXEC returns state to 0 and hi/lo to 0 asynchronously.
- Stall: stall=1 held for 3 clocks in FETCH keeps state=0 throughout; after release the state goes to 1.
- B mux, with immediate=16'hFFF0:
  - alu_src_b=2, opcode 0x09 → alu_b=FFFFFFF0;
  - alu_src_b=2, opcode 0x0D → alu_b=0000FFF0;
  - alu_src_b=3 → alu_b=FFFFFFC0;
  - alu_src_b=1 → alu_b=4;
  - alu_src_b=0 → alu_b=register_b.
- MULT: funct 0x18 with mult_div_result=64'h00000001_80000000 through EXEC → hi=00000001, lo=80000000. A following MFHI gives hi_lo_sel=1; MFLO gives hi_lo_sel=2.
- MTHI: funct 0x11 with reg_a=DEADBEEF → hi=DEADBEEF with the macro defined; hi unchanged without it.
- Non-HI/LO instruction (ADDU 0x21) through EXEC: hi/lo unchanged and hi_lo_sel=0.
